// File: rtl/aes_job_arbiter.sv
// -----------------------------------------------------------------------------
// aes_job_arbiter
//
// Round-robin job scheduler that lends a single aes_controller datapath to
// NUM_REQ requesters (e.g. DMA channels). The winner keeps the engine for a
// whole job. During that job the scheduler presents the winner's command,
// pulses start, counts completed 128-bit blocks and releases the engine. The
// engine is released on the last block, or on a watchdog timeout when the
// engine stalls.
//
// Ports
//   clk           block clock (s00_axis_aclk domain)
//   reset         asynchronous, active-high reset
//   req_valid     [NUM_REQ]                 requester i has a pending job
//   req_cmd       [NUM_REQ*CMD_WIDTH]       command of requester i
//   req_blocks    [NUM_REQ*BLK_CNT_WIDTH]   job length of requester i (blocks)
//   req_grant     [NUM_REQ]                 one-hot engine owner, held per job
//   req_done      [NUM_REQ]                 1-cycle pulse: job completed
//   req_err       [NUM_REQ]                 1-cycle pulse: zero length / timeout
//   aes_cmd       [CMD_WIDTH]               latched command of current job
//   aes_start     1-cycle pulse, start the job on the engine
//   aes_abort     1-cycle pulse, flush the engine after a timeout
//   aes_blk_done  engine finished one block (1-cycle pulse per block)
//   busy          high in every state except IDLE
//   blk_count     [BLK_CNT_WIDTH]           blocks completed in current job
// -----------------------------------------------------------------------------
module aes_job_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CMD_WIDTH     = 32,
  parameter int BLK_CNT_WIDTH = 12,
  parameter int TIMEOUT       = 65535
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]     req_cmd,
  input  logic [NUM_REQ*BLK_CNT_WIDTH-1:0] req_blocks,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_err,
  output logic [CMD_WIDTH-1:0]             aes_cmd,
  output logic                             aes_start,
  output logic                             aes_abort,
  input  logic                             aes_blk_done,
  output logic                             busy,
  output logic [BLK_CNT_WIDTH-1:0]         blk_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_ptr;
  logic [IDX_W-1:0]         r_cur;
  logic [BLK_CNT_WIDTH-1:0] r_job_len;
  logic [BLK_CNT_WIDTH-1:0] r_blk_count;
  logic [WD_W-1:0]          r_wd;
  logic [NUM_REQ-1:0]       r_grant;
  logic [NUM_REQ-1:0]       r_done;
  logic [NUM_REQ-1:0]       r_err;
  logic [CMD_WIDTH-1:0]     r_aes_cmd;
  logic                     r_start;
  logic                     r_abort;
  logic                     r_busy;

  logic                     w_found;
  logic [IDX_W-1:0]         w_win;
  logic [IDX_W-1:0]         w_cand;
  logic [NUM_REQ-1:0]       w_win_oh;
  logic [CMD_WIDTH-1:0]     w_win_cmd;
  logic [BLK_CNT_WIDTH-1:0] w_win_blocks;
  logic [WD_W:0]            w_wd_inc;
  logic                     w_timeout;
  logic                     w_last;
  logic [BLK_CNT_WIDTH-1:0] w_cnt_next;

  // Round-robin search: start one past the previous owner and wrap, so the
  // requester that was just served has the lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Select the winner's command/length with constant slices only.
  always_comb begin
    w_win_cmd    = '0;
    w_win_blocks = '0;
    w_win_oh     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_win_cmd    = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        w_win_blocks = req_blocks[i*BLK_CNT_WIDTH +: BLK_CNT_WIDTH];
        w_win_oh[i]  = 1'b1;
      end
    end
  end

  // The watchdog value this cycle would reach; hitting TIMEOUT means TIMEOUT
  // consecutive RUN cycles have passed without a completed block.
  assign w_wd_inc   = {1'b0, r_wd} + (WD_W+1)'(1);
  assign w_timeout  = (TIMEOUT != 0) && (w_wd_inc == (WD_W+1)'(TIMEOUT));
  // job_len is never 0 in RUN, so job_len-1 cannot underflow here.
  assign w_last     = (r_blk_count == (r_job_len - BLK_CNT_WIDTH'(1)));
  assign w_cnt_next = (&r_blk_count) ? r_blk_count
                                     : (r_blk_count + BLK_CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_cur       <= '0;
      r_job_len   <= '0;
      r_blk_count <= '0;
      r_wd        <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_aes_cmd   <= '0;
      r_start     <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle.
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_aes_cmd <= w_win_cmd;
            r_job_len <= w_win_blocks;
            r_cur     <= w_win;
            if (w_win_blocks == '0) begin
              // Reject without granting; moving the pointer lets the others
              // go first on the next scan.
              r_err <= w_win_oh;
              r_ptr <= w_win;
            end else begin
              r_grant     <= w_win_oh;
              r_start     <= 1'b1;
              r_busy      <= 1'b1;
              r_blk_count <= '0;
              r_wd        <= '0;
              r_state     <= S_START;
            end
          end
        end

        S_START: begin
          r_blk_count <= '0;
          r_wd        <= '0;
          r_state     <= S_RUN;
        end

        S_RUN: begin
          // A block completion takes priority over a simultaneous timeout.
          if (aes_blk_done) begin
            r_blk_count <= w_cnt_next;
            r_wd        <= '0;
            if (w_last) begin
              r_done  <= r_grant;
              r_grant <= '0;
              r_state <= S_DONE;
            end
          end else if (w_timeout) begin
            r_abort <= 1'b1;
            r_err   <= r_grant;
            r_grant <= '0;
            r_state <= S_ABORT;
          end else begin
            r_wd <= w_wd_inc[WD_W-1:0];
          end
        end

        S_DONE, S_ABORT: begin
          r_ptr   <= r_cur;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_grant = r_grant;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign aes_cmd   = r_aes_cmd;
  assign aes_start = r_start;
  assign aes_abort = r_abort;
  assign busy      = r_busy;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_job_arbiter
//
// Self-checking bench for aes_job_arbiter (NUM_REQ=4, TIMEOUT=16). Each
// scenario lives in its own task; expected grants / block counts are queued
// when stimulus is driven and popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_aes_job_arbiter;

  localparam int NR  = 4;
  localparam int CW  = 32;
  localparam int BW  = 12;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*CW-1:0]  req_cmd;
  logic [NR*BW-1:0]  req_blocks;
  logic [NR-1:0]     req_grant;
  logic [NR-1:0]     req_done;
  logic [NR-1:0]     req_err;
  logic [CW-1:0]     aes_cmd;
  logic              aes_start;
  logic              aes_abort;
  logic              aes_blk_done;
  logic              busy;
  logic [BW-1:0]     blk_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  aes_job_arbiter #(
    .NUM_REQ      (NR),
    .CMD_WIDTH    (CW),
    .BLK_CNT_WIDTH(BW),
    .TIMEOUT      (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_blocks  (req_blocks),
    .req_grant   (req_grant),
    .req_done    (req_done),
    .req_err     (req_err),
    .aes_cmd     (aes_cmd),
    .aes_start   (aes_start),
    .aes_abort   (aes_abort),
    .aes_blk_done(aes_blk_done),
    .busy        (busy),
    .blk_count   (blk_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    req_valid    = '0;
    req_cmd      = '0;
    req_blocks   = '0;
    aes_blk_done = 1'b0;
    reset        = 1'b1;
    #2;
    reset        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({req_grant, req_done, req_err, aes_start, aes_abort, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got grant=%b done=%b err=%b start=%b abort=%b busy=%b, want all 0",
               req_grant, req_done, req_err, aes_start, aes_abort, busy);
    end
    n_tests++;
    if (aes_cmd !== '0 || blk_count !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got cmd=%h blk=%0d, want 0/0", aes_cmd, blk_count);
    end
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || req_grant !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b grant=%b, want 0/0000", busy, req_grant);
    end
  endtask

  task automatic test_single_job();
    int e;
    do_reset();
    req_cmd[2*CW +: CW]    = 32'h00000A01;
    req_blocks[2*BW +: BW] = 12'd3;
    aes_blk_done = 1'b1;              // ignored while IDLE
    tick();
    n_tests++;
    if (blk_count !== 12'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle_blkdone: got blk=%0d busy=%b, want 0/0", blk_count, busy);
    end
    aes_blk_done = 1'b0;
    req_valid    = 4'b0100;
    tick();
    n_tests++;
    if (aes_start !== 1'b1 || req_grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_start: got start=%b grant=%b, want 1/0100", aes_start, req_grant);
    end
    n_tests++;
    if (aes_cmd !== 32'h00000A01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cmd: got cmd=%h busy=%b, want 00000a01/1", aes_cmd, busy);
    end
    req_valid    = '0;
    aes_blk_done = 1'b1;              // lands in START, must be ignored
    tick();
    aes_blk_done = 1'b0;
    n_tests++;
    if (aes_start !== 1'b0 || blk_count !== 12'd0) begin
      n_fail++;
      $display("FAIL single_start_pulse: got start=%b blk=%0d, want 0/0", aes_start, blk_count);
    end
    exp_q = {};
    for (int i = 1; i <= 3; i++) exp_q.push_back(i);
    for (int p = 0; p < 3; p++) begin
      aes_blk_done = 1'b1;
      tick();
      aes_blk_done = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if (blk_count !== BW'(e)) begin
        n_fail++;
        $display("FAIL single_blk_count: got %0d want %0d", blk_count, e);
      end
      if (p == 2) begin
        n_tests++;
        if (req_done !== 4'b0100 || aes_abort !== 1'b0) begin
          n_fail++;
          $display("FAIL single_done: got done=%b abort=%b, want 0100/0", req_done, aes_abort);
        end
      end else begin
        n_tests++;
        if (req_done !== 4'b0000) begin
          n_fail++;
          $display("FAIL single_early_done: got %b want 0000", req_done);
        end
        tick();
      end
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || req_done !== '0 || req_grant !== '0) begin
      n_fail++;
      $display("FAIL single_release: got busy=%b done=%b grant=%b, want 0/0000/0000",
               busy, req_done, req_grant);
    end
    n_tests++;
    if (aes_cmd !== 32'h00000A01) begin
      n_fail++;
      $display("FAIL single_cmd_hold: got %h want 00000a01", aes_cmd);
    end
  endtask

  task automatic test_fairness();
    int e;
    logic [NR-1:0] eg;
    int cyc;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_cmd[i*CW +: CW]    = 32'h100 + i;
      req_blocks[i*BW +: BW] = 12'd1;
    end
    aes_blk_done = 1'b1;
    req_valid    = 4'b1111;
    exp_q = {};
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 80) begin
      tick();
      cyc++;
      if (aes_start === 1'b1) begin
        e  = exp_q.pop_front();
        eg = NR'(1) << e;
        n_tests++;
        if (req_grant !== eg || aes_cmd !== (32'h100 + e)) begin
          n_fail++;
          $display("FAIL fair_order: got grant=%b cmd=%h want grant=%b cmd=%h",
                   req_grant, aes_cmd, eg, 32'h100 + e);
        end
        n_tests++;
        if (aes_abort !== 1'b0) begin
          n_fail++;
          $display("FAIL fair_start_abort: got abort=%b with start, want 0", aes_abort);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fair_timeout: got %0d grants outstanding want 0", exp_q.size());
    end
    req_valid    = '0;
    aes_blk_done = 1'b0;
  endtask

  task automatic test_zero_length();
    do_reset();
    req_cmd[1*CW +: CW]    = 32'h11;
    req_blocks[1*BW +: BW] = 12'd0;
    req_cmd[3*CW +: CW]    = 32'h33;
    req_blocks[3*BW +: BW] = 12'd2;
    req_valid = 4'b1010;
    tick();
    n_tests++;
    if (req_err !== 4'b0010 || aes_start !== 1'b0 || req_grant !== '0) begin
      n_fail++;
      $display("FAIL zero_err: got err=%b start=%b grant=%b, want 0010/0/0000",
               req_err, aes_start, req_grant);
    end
    n_tests++;
    if (aes_cmd !== 32'h11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_latch: got cmd=%h busy=%b, want 00000011/0", aes_cmd, busy);
    end
    req_valid = 4'b1000;
    tick();
    n_tests++;
    if (req_grant !== 4'b1000 || aes_start !== 1'b1 || req_err !== '0) begin
      n_fail++;
      $display("FAIL zero_next: got grant=%b start=%b err=%b, want 1000/1/0000",
               req_grant, aes_start, req_err);
    end
    req_valid = '0;
    tick();
    aes_blk_done = 1'b1;
    tick();
    tick();
    aes_blk_done = 1'b0;
    n_tests++;
    if (req_done !== 4'b1000 || req_err !== '0) begin
      n_fail++;
      $display("FAIL zero_next_done: got done=%b err=%b, want 1000/0000", req_done, req_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req_blocks[0 +: BW] = 12'd2;
    req_cmd[0 +: CW]    = 32'hDEAD0001;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    aes_blk_done = 1'b1;
    tick();
    aes_blk_done = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      n_tests++;
      if (aes_abort !== 1'b0 || req_err !== '0) begin
        n_fail++;
        $display("FAIL tmo_early: cycle %0d got abort=%b err=%b, want 0/0000", i, aes_abort, req_err);
      end
    end
    tick();
    n_tests++;
    if (aes_abort !== 1'b1 || req_err !== 4'b0001) begin
      n_fail++;
      $display("FAIL tmo_abort: got abort=%b err=%b, want 1/0001", aes_abort, req_err);
    end
    n_tests++;
    if (req_done !== '0 || blk_count !== 12'd1 || aes_start !== 1'b0 || req_grant !== '0) begin
      n_fail++;
      $display("FAIL tmo_state: got done=%b blk=%0d start=%b grant=%b, want 0000/1/0/0000",
               req_done, blk_count, aes_start, req_grant);
    end
    tick();
    n_tests++;
    if (aes_abort !== 1'b0 || busy !== 1'b0 || req_err !== '0) begin
      n_fail++;
      $display("FAIL tmo_release: got abort=%b busy=%b err=%b, want 0/0/0000", aes_abort, busy, req_err);
    end
  endtask

  task automatic test_coincidence();
    do_reset();
    req_blocks[0 +: BW] = 12'd2;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    aes_blk_done = 1'b1;
    tick();
    aes_blk_done = 1'b0;
    for (int i = 0; i < TMO - 1; i++) tick();
    n_tests++;
    if (aes_abort !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL coin_pre: got abort=%b busy=%b, want 0/1", aes_abort, busy);
    end
    aes_blk_done = 1'b1;              // last block on the timeout cycle
    tick();
    aes_blk_done = 1'b0;
    n_tests++;
    if (req_done !== 4'b0001 || aes_abort !== 1'b0 || req_err !== '0) begin
      n_fail++;
      $display("FAIL coin_done: got done=%b abort=%b err=%b, want 0001/0/0000",
               req_done, aes_abort, req_err);
    end
    n_tests++;
    if (blk_count !== 12'd2) begin
      n_fail++;
      $display("FAIL coin_blk: got %0d want 2", blk_count);
    end
    tick();
    n_tests++;
    if (aes_abort !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_release: got abort=%b busy=%b, want 0/0", aes_abort, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_blocks[0 +: BW] = 12'd5;
    req_cmd[0 +: CW]    = 32'hC0;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    aes_blk_done = 1'b1;
    tick();
    tick();
    aes_blk_done = 1'b0;
    n_tests++;
    if (blk_count !== 12'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got blk=%0d busy=%b, want 2/1", blk_count, busy);
    end
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({req_grant, req_done, req_err, aes_start, aes_abort, busy} !== '0 ||
        aes_cmd !== '0 || blk_count !== '0) begin
      n_fail++;
      $display("FAIL areset_clear: got grant=%b done=%b err=%b start=%b abort=%b busy=%b cmd=%h blk=%0d, want all 0",
               req_grant, req_done, req_err, aes_start, aes_abort, busy, aes_cmd, blk_count);
    end
    #1;
    reset = 1'b0;
    req_blocks[1*BW +: BW] = 12'd1;
    req_valid = 4'b0011;
    tick();
    n_tests++;
    if (req_grant !== 4'b0001 || aes_start !== 1'b1 || req_done !== '0 || req_err !== '0) begin
      n_fail++;
      $display("FAIL areset_first: got grant=%b start=%b done=%b err=%b, want 0001/1/0000/0000",
               req_grant, aes_start, req_done, req_err);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    req_valid    = '0;
    req_cmd      = '0;
    req_blocks   = '0;
    aes_blk_done = 1'b0;
    test_reset();
    test_single_job();
    test_fairness();
    test_zero_length();
    test_timeout();
    test_coincidence();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Round-robin job scheduler that shares one aes_controller datapath between NUM_REQ requesters, such as multiple DMA channels.
- Grants the engine for a whole job: command, key/IV and N 128-bit blocks. Presents the latched command, pulses start, counts completed blocks and releases the engine on the last block or on a watchdog timeout.
- Sits between the requester front-ends and the aes_controller command/start inputs, in the s00_axis_aclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_WIDTH, 32, width of one AES command word (`WORD_S).
- BLK_CNT_WIDTH, 12, width of the per-job 128-bit block count.
- TIMEOUT, 65535, max cycles in RUN without aes_blk_done before abort; 0 disables the watchdog.

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a pending job.
- req_cmd  in  NUM_REQ*CMD_WIDTH  command of requester i, slice [i*CMD_WIDTH +: CMD_WIDTH].
- req_blocks  in  NUM_REQ*BLK_CNT_WIDTH  job length in blocks, slice [i*BLK_CNT_WIDTH +: BLK_CNT_WIDTH].
- req_grant  out  NUM_REQ  one-hot owner of the engine; held for the whole job.
- req_done  out  NUM_REQ  1-cycle pulse: requester i job completed.
- req_err  out  NUM_REQ  1-cycle pulse: requester i job rejected (zero length) or aborted (timeout).
- aes_cmd  out  CMD_WIDTH  latched command of the current job.
- aes_start  out  1  1-cycle pulse: start the job on the engine.
- aes_abort  out  1  1-cycle pulse: flush the engine after a timeout.
- aes_blk_done  in  1  engine completed one 128-bit block (1-cycle pulse per block).
- busy  out  1  high in every state except IDLE.
- blk_count  out  BLK_CNT_WIDTH  blocks completed in the current job.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All outputs 0: req_grant, req_done, req_err, aes_cmd, aes_start, aes_abort, busy, blk_count.
  - Round-robin pointer ptr=NUM_REQ-1, so requester 0 has first priority.
  - Asserting reset mid-job aborts silently: no done or err pulse, aes_abort stays 0.
- States: IDLE, START, RUN, DONE, ABORT.
- IDLE:
  - Scan req_valid from (ptr+1) mod NUM_REQ upward with wrap; the first set bit is winner w.
  - Latch req_cmd[w] into aes_cmd and req_blocks[w] into job_len.
  - If req_blocks[w]==0: pulse req_err[w] next cycle, set ptr=w, stay IDLE; no grant is issued.
  - Otherwise: next cycle req_grant=onehot(w), state=START.
  - Latency from req_valid sampled in IDLE to aes_start: 1 cycle.
- START: aes_start=1 for exactly this cycle, blk_count=0, watchdog=0, then RUN.
- RUN:
  - Each aes_blk_done increments blk_count and clears the watchdog.
  - If aes_blk_done arrives when blk_count==job_len-1, go to DONE.
  - Otherwise the watchdog increments each cycle. At watchdog==TIMEOUT (TIMEOUT!=0), go to ABORT.
  - If aes_blk_done and timeout coincide in the same cycle, aes_blk_done wins.
- DONE: pulse req_done[w], clear req_grant, set ptr=w, return to IDLE.
- ABORT: pulse aes_abort and req_err[w], clear req_grant, set ptr=w, return to IDLE.
- A new grant is possible at the earliest on the cycle after DONE/ABORT (IDLE evaluates that cycle). The minimum job turnaround is therefore 3 cycles plus the block time.
- aes_cmd holds its value after a job completes until the next latch.
- Requester inputs:
  - req_valid, req_cmd and req_blocks are sampled only in IDLE. Changes while granted are ignored.
  - A requester must drop req_valid on or before the cycle after its req_done, or it is re-queued. It is then served after all other pending requesters.
- aes_blk_done outside RUN is ignored; blk_count is unchanged.
- Counter widths:
  - blk_count saturates at all-ones and never wraps; job_len <= 2^BLK_CNT_WIDTH-1.
  - The watchdog is 16 bits wide.
- Exactly one bit of req_grant, req_done and req_err may be set in any cycle. aes_start and aes_abort are never set together.

Test Plan:
- Single job, req 2, blocks=3, cmd=0x00000A01:
  - aes_start 1 cycle after req_valid; aes_cmd=0x00000A01; req_grant=4'b0100.
  - Three aes_blk_done pulses give blk_count 1,2,3.
  - req_done[2] fires 1 cycle after the 3rd pulse; busy returns to 0.
- Fairness, all 4 requesters valid continuously, blocks=1 each: grant order after reset is 0,1,2,3,0. No requester is granted twice before the others.
- Zero-length job, req 1, blocks=0:
  - req_err[1] pulses; no aes_start; req_grant stays 0.
  - Next winner with req 1 and req 3 valid is req 3.
- Timeout, TIMEOUT=16, blocks=2, one aes_blk_done then silence:
  - aes_abort and req_err[w] pulse 16 cycles after the last pulse; no req_done; blk_count=1.
- Coincidence, TIMEOUT=16, aes_blk_done of the last block on the cycle the watchdog reaches 16: req_done asserted, no aes_abort.
- Async reset mid-RUN (blocks=5, 2 done):
  - All outputs 0 immediately, with no clock edge required.
  - After release with req 0 and req 1 valid, req 0 is granted first.
